// File: rtl/spmm_rhs_buffer_if.sv
// Handshake bundle between the RHS matrix source, the ping-pong buffer and the PE array.
// The master side is the producer/consumer pair; the slave side is the buffer itself.
interface spmm_rhs_buffer_if #(
  parameter int N = 16,
  parameter int W = 8
);
  logic                         rhs_ready;
  logic                         rhs_start;
  logic [3:0][N-1:0][W-1:0]     rhs_data;
  logic                         cons_valid;
  logic [N-1:0][N-1:0][W-1:0]   cons_col;
  logic                         cons_done;
  logic                         load_bank;
  logic                         read_bank;

  modport master (
    input  rhs_ready,
    input  cons_valid,
    input  cons_col,
    input  load_bank,
    input  read_bank,
    output rhs_start,
    output rhs_data,
    output cons_done
  );

  modport slave (
    output rhs_ready,
    output cons_valid,
    output cons_col,
    output load_bank,
    output read_bank,
    input  rhs_start,
    input  rhs_data,
    input  cons_done
  );
endinterface

// File: rtl/spmm_rhs_buffer.sv
// Two-bank RHS staging buffer: fills one bank 4 rows per beat while the other
// bank is presented column-major (transposed) to the PE array.
module spmm_rhs_buffer #(
  parameter int N = 16,
  parameter int W = 8
) (
  input  logic              clock,
  input  logic              reset,
  spmm_rhs_buffer_if.slave  bus
);

  localparam int BEATS = N / 4;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic {
    IDLE,
    LOAD
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic [CW-1:0]   beat;
  logic [1:0]      full_count;
  logic [1:0]      full_next;
  logic            load_sel;
  logic            read_sel;
  logic            ready;
  logic            write_en;
  logic            last_beat;
  logic            done_acc;

  logic [N-1:0][W-1:0]        mem [2][N];
  logic [N-1:0][N-1:0][W-1:0] cons_col;

  // Loader next-state logic; beat selects which group of 4 rows is written this cycle
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    beat       = '0;
    write_en   = 1'b0;
    last_beat  = 1'b0;
    ready      = (state == IDLE) && (full_count < 2'd2);
    done_acc   = bus.cons_done && (full_count != 2'd0);
    case (state)
      IDLE: begin
        if (bus.rhs_start && ready) begin
          write_en = 1'b1;
          if (BEATS == 1) begin
            last_beat = 1'b1;
          end else begin
            cnt_next   = CW'(1);
            state_next = LOAD;
          end
        end
      end
      LOAD: begin
        write_en = 1'b1;
        beat     = cnt;
        if (cnt == CW'(BEATS - 1)) begin
          last_beat  = 1'b1;
          cnt_next   = '0;
          state_next = IDLE;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
    full_next = full_count + {1'b0, last_beat} - {1'b0, done_acc};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      full_count <= '0;
      load_sel   <= 1'b0;
      read_sel   <= 1'b0;
    end else begin
      state      <= state_next;
      cnt        <= cnt_next;
      full_count <= full_next;
      if (last_beat) begin
        load_sel <= ~load_sel;
      end
      if (done_acc) begin
        read_sel <= ~read_sel;
      end
    end
  end

  // Bank storage is deliberately not reset; nothing reads it until a full load lands
  always_ff @(posedge clock) begin
    if (write_en) begin
      for (int r = 0; r < N; r++) begin
        if (beat == CW'(r / 4)) begin
          mem[load_sel][r] <= bus.rhs_data[r % 4];
        end
      end
    end
  end

  always_comb begin
    cons_col = '0;
    for (int j = 0; j < N; j++) begin
      for (int k = 0; k < N; k++) begin
        cons_col[j][k] = mem[read_sel][k][j];
      end
    end
  end

  assign bus.rhs_ready  = ready;
  assign bus.cons_valid = (full_count != 2'd0);
  assign bus.cons_col   = cons_col;
  assign bus.load_bank  = load_sel;
  assign bus.read_bank  = read_sel;

endmodule

// File: tb/tb_spmm_rhs_buffer.sv
// Randomized bench for spmm_rhs_buffer against a matrix-queue reference model.
// Matrices are identified by a seed; element values are a pure function of seed, row and column.
module tb_spmm_rhs_buffer;

  localparam int N     = 16;
  localparam int W     = 8;
  localparam int BEATS = N / 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  spmm_rhs_buffer_if #(.N(N), .W(W)) bus ();

  spmm_rhs_buffer #(.N(N), .W(W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model: a FIFO of completed matrices plus the load in progress
  bit m_loading;
  int m_beat;
  int m_seed;
  int m_full[$];
  int m_loads;
  int m_dones;

  function automatic int gen(int seed, int r, int c);
    if (seed == 0) return (r * 16 + c) % 256;
    return ((seed * 131) ^ (r * 29 + c * 7 + r * c * 3)) & 255;
  endfunction

  task automatic check_value(string tag, logic [31:0] observed, logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic model_reset();
    m_loading = 1'b0;
    m_beat    = 0;
    m_full.delete();
    m_loads   = 0;
    m_dones   = 0;
  endtask

  task automatic model_step(bit start, int seed, bit done);
    bit ready;
    bit acc;
    bit completed;
    int cseed;
    ready     = !m_loading && (m_full.size() < 2);
    acc       = done && (m_full.size() > 0);
    completed = 1'b0;
    cseed     = 0;
    if (m_loading) begin
      if (m_beat == BEATS - 1) begin
        completed = 1'b1;
        m_loading = 1'b0;
        cseed     = m_seed;
      end else begin
        m_beat++;
      end
    end else if (start && ready) begin
      m_seed = seed;
      cseed  = seed;
      if (BEATS == 1) begin
        completed = 1'b1;
      end else begin
        m_loading = 1'b1;
        m_beat    = 1;
      end
    end
    if (acc) begin
      void'(m_full.pop_front());
      m_dones++;
    end
    if (completed) begin
      m_full.push_back(cseed);
      m_loads++;
    end
  endtask

  task automatic check_output();
    int mism;
    check_value("rhs_ready", bus.rhs_ready, (!m_loading && m_full.size() < 2) ? 1 : 0);
    check_value("cons_valid", bus.cons_valid, (m_full.size() > 0) ? 1 : 0);
    check_value("load_bank", bus.load_bank, m_loads % 2);
    check_value("read_bank", bus.read_bank, m_dones % 2);
    if (m_full.size() > 0) begin
      mism = 0;
      for (int j = 0; j < N; j++) begin
        for (int k = 0; k < N; k++) begin
          if (bus.cons_col[j][k] !== W'(gen(m_full[0], k, j))) mism++;
        end
      end
      check_value("cons_col_mismatches", mism, 0);
    end
  endtask

  // Drives one cycle; during a load the source always streams the accepted matrix
  task automatic apply_stimulus(bit start, int seed, bit done);
    int rseed;
    int b;
    if (m_loading) begin
      rseed = m_seed;
      b     = m_beat;
    end else begin
      rseed = seed;
      b     = 0;
    end
    for (int i = 0; i < 4; i++) begin
      for (int c = 0; c < N; c++) begin
        if (m_loading || start) bus.rhs_data[i][c] = W'(gen(rseed, 4 * b + i, c));
        else                    bus.rhs_data[i][c] = W'($urandom);
      end
    end
    bus.rhs_start = start;
    bus.cons_done = done;
    @(posedge clock);
    model_step(start, seed, done);
    #1;
    bus.rhs_start = 1'b0;
    bus.cons_done = 1'b0;
    check_output();
  endtask

  task automatic do_reset(int cycles);
    reset         = 1'b1;
    bus.rhs_start = 1'b0;
    bus.cons_done = 1'b0;
    repeat (cycles) @(posedge clock);
    #1;
    model_reset();
    check_output();
    reset = 1'b0;
  endtask

  task automatic load_matrix(int seed, bit done_on_last);
    apply_stimulus(1'b1, seed, 1'b0);
    for (int b = 1; b < BEATS; b++) begin
      apply_stimulus(1'b0, seed, done_on_last && (b == BEATS - 1));
    end
  endtask

  initial begin
    bus.rhs_start = 1'b0;
    bus.cons_done = 1'b0;
    bus.rhs_data  = '0;
    model_reset();

    do_reset(2);
    check_value("reset_ready", bus.rhs_ready, 1);
    check_value("reset_valid", bus.cons_valid, 0);

    // Spurious release with nothing valid
    apply_stimulus(1'b0, 0, 1'b1);

    // Single load of the ramp matrix
    load_matrix(0, 1'b0);
    check_value("col3_5", bus.cons_col[3][5], 83);
    check_value("col15_15", bus.cons_col[15][15], 255);
    apply_stimulus(1'b0, 0, 1'b1);

    // Back-to-back loads fill both banks; a third start is ignored
    load_matrix(11, 1'b0);
    load_matrix(22, 1'b0);
    check_value("both_full_ready", bus.rhs_ready, 0);
    apply_stimulus(1'b1, 33, 1'b0);
    check_value("m1_still_shown", bus.cons_col[2][7], gen(11, 7, 2));
    apply_stimulus(1'b0, 0, 1'b1);
    check_value("m2_after_done", bus.cons_col[2][7], gen(22, 7, 2));

    // Release coincident with the final beat of the next matrix
    load_matrix(44, 1'b1);
    check_value("simul_valid", bus.cons_valid, 1);
    check_value("m3_after_simul", bus.cons_col[9][1], gen(44, 1, 9));
    apply_stimulus(1'b0, 0, 1'b1);

    // rhs_start held high through LOAD must not restart or reseed the load
    apply_stimulus(1'b1, 55, 1'b0);
    for (int b = 1; b < BEATS; b++) apply_stimulus(1'b1, 66 + b, 1'b0);
    check_value("spurious_start_data", bus.cons_col[4][12], gen(55, 12, 4));
    apply_stimulus(1'b0, 0, 1'b1);

    // Reset in the middle of a load
    apply_stimulus(1'b1, 77, 1'b0);
    apply_stimulus(1'b0, 77, 1'b0);
    do_reset(1);
    check_value("midreset_valid", bus.cons_valid, 0);
    check_value("midreset_ready", bus.rhs_ready, 1);
    load_matrix(88, 1'b0);
    check_value("post_reset_bank", bus.read_bank, 0);
    apply_stimulus(1'b0, 0, 1'b1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      apply_stimulus(1'($urandom_range(0, 1)), int'($urandom_range(1, 1000)),
                     ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
